// File: rtl/vend_pkg.sv
// Shared types and coin-code constants for the parametrised vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_01   = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_11   = 2'b11;

endpackage

// File: rtl/vend_coin_dec.sv
// Combinational coin decoder: turns a two-bit coin code into its value in credit units.
module vend_coin_dec
    import vend_pkg::*;
#(
    parameter int CW   = 6,
    parameter int VAL1 = 1,
    parameter int VAL2 = 2,
    parameter int VAL3 = 5
) (
    input  logic [1:0]    code,
    output logic [CW-1:0] value
);

    always_comb begin
        value = '0;
        case (code)
            COIN_01: value = CW'(VAL1);
            COIN_10: value = CW'(VAL2);
            COIN_11: value = CW'(VAL3);
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit accumulation, sale, unit-pulse change and refund,
// with Moore or Mealy dispense timing selected by MEALY.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int CW    = 6,
    parameter int PRICE = 5,
    parameter int VAL1  = 1,
    parameter int VAL2  = 2,
    parameter int VAL3  = 5,
    parameter int MEALY = 0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [1:0]    D_in,
    input  logic          Cancel,
    output logic          D_out,
    output logic          Chg_pulse,
    output logic          Busy,
    output logic [CW-1:0] Credit
);

    localparam int MAXV12 = (VAL1 > VAL2) ? VAL1 : VAL2;
    localparam int MAXV   = (MAXV12 > VAL3) ? MAXV12 : VAL3;
    localparam int CWX    = CW + 1;
    localparam logic [CW:0] PRICE_X = CWX'(PRICE);

    // Credit below PRICE plus the largest coin must fit, so the register never wraps.
    generate
        if (PRICE < 1 || (PRICE + MAXV - 1) >= (2 ** CW)) begin : g_bad_params
            $error("vend_ctrl_param: PRICE must be >= 1 and PRICE+max(VAL)-1 must fit in CW bits");
        end
    endgenerate

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] credit_next;
    logic [CW-1:0] coin_val;
    logic [CW:0]   sum;
    logic          coin;
    logic          sale_now;

    vend_coin_dec #(
        .CW   (CW),
        .VAL1 (VAL1),
        .VAL2 (VAL2),
        .VAL3 (VAL3)
    ) u_coin_dec (
        .code  (D_in),
        .value (coin_val)
    );

    assign coin = (D_in != COIN_NONE);
    assign sum  = {1'b0, Credit} + {1'b0, coin_val};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= IDLE;
            Credit <= '0;
        end else begin
            state  <= state_next;
            Credit <= credit_next;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = Credit;
        sale_now    = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                // Cancel has priority; a coin arriving alongside it is dropped.
                if (Cancel) begin
                    if (state == ACCUM && Credit != '0) begin
                        state_next = CHANGE;
                    end
                end else if (coin) begin
                    if (sum >= PRICE_X) begin
                        sale_now    = 1'b1;
                        state_next  = VEND;
                        credit_next = CW'(sum - PRICE_X);
                    end else begin
                        state_next  = ACCUM;
                        credit_next = sum[CW-1:0];
                    end
                end
            end
            VEND: begin
                state_next = (Credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                credit_next = Credit - CW'(1);
                if (Credit <= CW'(1)) begin
                    state_next  = IDLE;
                    credit_next = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    assign Busy      = (state == VEND) || (state == CHANGE);
    assign Chg_pulse = (state == CHANGE);

    generate
        if (MEALY != 0) begin : g_mealy
            assign D_out = sale_now && Reset;
        end else begin : g_moore
            assign D_out = (state == VEND);
        end
    endgenerate

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: Moore and Mealy instances driven in lockstep, directed scenarios
// followed by randomized traffic checked against a sale/refund model.
module tb_vend_ctrl_param;

    localparam int CW    = 6;
    localparam int PRICE = 5;
    localparam int V1    = 1;
    localparam int V2    = 2;
    localparam int V3    = 5;

    logic          Clk    = 1'b0;
    logic          Reset  = 1'b0;
    logic          Cancel = 1'b0;
    logic [1:0]    D_in   = 2'b00;

    logic          d0, chg0, busy0;
    logic [CW-1:0] credit0;
    logic          d1, chg1, busy1;
    logic [CW-1:0] credit1;

    int errors = 0;
    int checks = 0;

    // Model: amount held, whether a sale is being dispensed, whether units are being returned.
    int            m_credit = 0;
    bit            m_sale   = 0;
    bit            m_ref    = 0;
    logic [1:0]    cur_code   = 2'b00;
    logic          cur_cancel = 1'b0;
    logic          cur_rst    = 1'b0;

    logic [CW-1:0] exp_credit;
    logic          exp_busy, exp_chg, exp_d0, exp_d1;

    vend_ctrl_param #(.CW(CW), .PRICE(PRICE), .VAL1(V1), .VAL2(V2), .VAL3(V3), .MEALY(0)) u_moore (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(d0), .Chg_pulse(chg0), .Busy(busy0), .Credit(credit0)
    );

    vend_ctrl_param #(.CW(CW), .PRICE(PRICE), .VAL1(V1), .VAL2(V2), .VAL3(V3), .MEALY(1)) u_mealy (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(d1), .Chg_pulse(chg1), .Busy(busy1), .Credit(credit1)
    );

    always #5 Clk = ~Clk;

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return V1;
            2'b10:   return V2;
            2'b11:   return V3;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        int s;
        if (!cur_rst) begin
            m_credit = 0; m_sale = 0; m_ref = 0;
        end else if (m_sale) begin
            m_sale = 0;
            m_ref  = (m_credit > 0);
        end else if (m_ref) begin
            m_credit--;
            if (m_credit == 0) m_ref = 0;
        end else if (cur_cancel) begin
            if (m_credit > 0) m_ref = 1;
        end else if (cur_code != 2'b00) begin
            s = m_credit + coin_units(cur_code);
            if (s >= PRICE) begin
                m_credit = s - PRICE;
                m_sale   = 1;
            end else begin
                m_credit = s;
            end
        end
    endtask

    // One clock: the model consumes the inputs of the previous cycle at the edge, then new
    // inputs are applied and the bench waits for the falling edge to observe outputs.
    task automatic cycle(input logic [1:0] code, input logic cancel, input logic rst);
        @(posedge Clk);
        model_edge();
        #1;
        D_in = code; Cancel = cancel; Reset = rst;
        cur_code = code; cur_cancel = cancel; cur_rst = rst;
        exp_credit = CW'(m_credit);
        exp_busy   = m_sale | m_ref;
        exp_chg    = m_ref;
        exp_d0     = m_sale;
        exp_d1     = rst && !(m_sale || m_ref) && !cancel && (code != 2'b00)
                     && (m_credit + coin_units(code) >= PRICE);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        checks++; if (credit0 !== 0 || credit1 !== 0) begin errors++; $display("FAIL reset_credit got=%0d/%0d want=0", credit0, credit1); end
        checks++; if ({d0, chg0, busy0, d1, chg1, busy1} !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b want=000000", {d0, chg0, busy0, d1, chg1, busy1}); end
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b01, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if (credit0 !== 3) begin errors++; $display("FAIL reset_pre_credit got=%0d want=3", credit0); end
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        checks++; if (credit0 !== 0 || credit1 !== 0) begin errors++; $display("FAIL reset_mid_accum got=%0d/%0d want=0", credit0, credit1); end
        checks++; if ({d0, chg0, busy0, d1, chg1, busy1} !== 6'b0) begin errors++; $display("FAIL reset_mid_outputs got=%b want=000000", {d0, chg0, busy0, d1, chg1, busy1}); end
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if (credit0 !== 0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_after got credit=%0d busy=%b want=0/0", credit0, busy0); end
    endtask

    task automatic test_exact_sale();
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b1);
        checks++; if (credit0 !== 2) begin errors++; $display("FAIL sale_credit1 got=%0d want=2", credit0); end
        cycle(2'b01, 1'b0, 1'b1);
        checks++; if (credit0 !== 4) begin errors++; $display("FAIL sale_credit2 got=%0d want=4", credit0); end
        checks++; if (d1 !== 1'b1 || d0 !== 1'b0) begin errors++; $display("FAIL sale_coin_cycle d_out moore/mealy got=%b/%b want=0/1", d0, d1); end
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if (d0 !== 1'b1 || d1 !== 1'b0) begin errors++; $display("FAIL sale_vend_cycle d_out moore/mealy got=%b/%b want=1/0", d0, d1); end
        checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1 || chg0 !== 1'b0 || credit0 !== 0) begin errors++; $display("FAIL sale_vend_state busy=%b chg=%b credit=%0d want busy=1 chg=0 credit=0", busy0, chg0, credit0); end
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if ({d0, chg0, busy0, d1, chg1, busy1} !== 6'b0) begin errors++; $display("FAIL sale_after got=%b want=000000", {d0, chg0, busy0, d1, chg1, busy1}); end
    endtask

    task automatic test_change();
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b11, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if (credit0 !== 4 || d0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL change_vend got credit=%0d d_out=%b busy=%b want 4/1/1", credit0, d0, busy0); end
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 1'b0, 1'b1);
            checks++;
            if (chg0 !== 1'b1 || chg1 !== 1'b1 || credit0 !== CW'(4 - i) || d0 !== 1'b0 || d1 !== 1'b0) begin
                errors++; $display("FAIL change_pulse%0d got chg=%b credit=%0d d_out=%b want chg=1 credit=%0d d_out=0", i, chg0, credit0, d0, 4 - i);
            end
        end
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if (chg0 !== 1'b0 || busy0 !== 1'b0 || credit0 !== 0) begin errors++; $display("FAIL change_end got chg=%b busy=%b credit=%0d want 0/0/0", chg0, busy0, credit0); end
    endtask

    task automatic test_cancel();
        int pulses;
        int douts;
        pulses = 0; douts = 0;
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b01, 1'b0, 1'b1);
        cycle(2'b00, 1'b1, 1'b1);
        checks++; if (credit0 !== 3) begin errors++; $display("FAIL cancel_credit got=%0d want=3", credit0); end
        for (int i = 0; i < 6; i++) begin
            cycle(2'b00, 1'b0, 1'b1);
            pulses += int'(chg0);
            douts  += int'(d0) + int'(d1);
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL cancel_refund pulses got=%0d want=3", pulses); end
        checks++; if (douts != 0) begin errors++; $display("FAIL cancel_no_dispense d_out cycles got=%0d want=0", douts); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(2'b00, (i < 3) ? 1'b1 : 1'b0, 1'b1);
            pulses += int'(chg0) + int'(chg1) + int'(busy0);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL cancel_idle activity got=%0d want=0", pulses); end
    endtask

    task automatic test_ignore();
        int pulses;
        pulses = 0;
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle((i == 0 || i == 2) ? 2'b11 : 2'b00, (i == 3) ? 1'b1 : 1'b0, 1'b1);
            pulses += int'(chg0);
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL ignore_busy pulses got=%0d want=4", pulses); end
        checks++; if (credit0 !== 0 || busy0 !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got credit=%0d busy=%b want 0/0", credit0, busy0); end
        cycle(2'b01, 1'b0, 1'b1);
        cycle(2'b10, 1'b1, 1'b1);
        checks++; if (credit0 !== 1) begin errors++; $display("FAIL cancel_coin_credit got=%0d want=1", credit0); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(2'b00, 1'b0, 1'b1);
            pulses += int'(chg0);
        end
        checks++; if (pulses != 1 || credit0 !== 0) begin errors++; $display("FAIL cancel_coin_refund pulses=%0d credit=%0d want 1/0", pulses, credit0); end
    endtask

    task automatic test_mealy_reset();
        int pulses;
        pulses = 0;
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b11, 1'b0, 1'b1);
        checks++; if (d1 !== 1'b1 || d0 !== 1'b0) begin errors++; $display("FAIL mealy_coin d_out moore/mealy got=%b/%b want=0/1", d0, d1); end
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b0);
        checks++; if (chg1 !== 1'b1 || credit1 !== 3) begin errors++; $display("FAIL mrst_second_pulse got chg=%b credit=%0d want 1/3", chg1, credit1); end
        cycle(2'b00, 1'b0, 1'b1);
        checks++; if (chg0 !== 1'b0 || chg1 !== 1'b0 || credit0 !== 0 || credit1 !== 0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL mrst_stop got chg=%b/%b credit=%0d/%0d busy=%b want 0/0 0/0 0", chg0, chg1, credit0, credit1, busy1);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(2'b00, 1'b0, 1'b1);
            pulses += int'(chg0) + int'(chg1);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL mrst_no_more_pulses got=%0d want=0", pulses); end
    endtask

    task automatic test_random();
        logic [1:0] code;
        logic       cancel;
        logic       rst;
        int         bad;
        for (int i = 0; i < 600; i++) begin
            code   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            cancel = ($urandom_range(0, 7) == 0);
            rst    = !($urandom_range(0, 79) == 0);
            cycle(code, cancel, rst);
            bad = 0;
            if (credit0 !== exp_credit || credit1 !== exp_credit) bad++;
            if (busy0 !== exp_busy || busy1 !== exp_busy) bad++;
            if (chg0 !== exp_chg || chg1 !== exp_chg) bad++;
            if (d0 !== exp_d0 || d1 !== exp_d1) bad++;
            if ((d0 && chg0) || (d1 && chg1)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random cyc=%0d got credit=%0d/%0d busy=%b/%b chg=%b/%b dout=%b/%b want credit=%0d busy=%b chg=%b dout=%b/%b",
                         i, credit0, credit1, busy0, busy1, chg0, chg1, d0, d1, exp_credit, exp_busy, exp_chg, exp_d0, exp_d1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_sale();
        test_change();
        test_cancel();
        test_ignore();
        test_mealy_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised vending controller, the successor to the fixed Mealy/Moore coin FSMs. It generalises price, coin values and credit width, and selects Mealy or Moore dispense timing by parameter. It adds behaviour the earlier FSMs lack: change return as a unit pulse stream, cancel/refund, and a Busy indicator. It sits below the vend test top and is driven by the same coin-code input D_in.

Parameters:
CW, 6, credit register width in coin units
PRICE, 5, product price in units; must be at least 1
VAL1, 1, units credited for D_in=01
VAL2, 2, units credited for D_in=10
VAL3, 5, units credited for D_in=11
MEALY, 0, 0 = Moore (registered dispense), 1 = Mealy (combinational dispense)

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  synchronous, active-low reset
D_in  input  2  coin code per cycle: 00 none, 01/10/11 one coin of VAL1/VAL2/VAL3
Cancel  input  1  refund request, sampled each cycle
D_out  output  1  dispense pulse, exactly 1 cycle per sale
Chg_pulse  output  1  one unit of change or refund per high cycle
Busy  output  1  high in VEND or CHANGE; coins are not accepted
Credit  output  CW  current credit in units (registered)

Behaviour:
- Reset sampled low at a Clk edge: state IDLE, Credit=0, D_out=0, Chg_pulse=0, Busy=0. Reset overrides every other input. Reset mid-CHANGE drops the remaining change; no further pulses.
- Elaboration check: PRICE+max(VAL1..VAL3)-1 < 2**CW. Credit therefore never overflows; no saturation logic.
- State encoding is decided: IDLE, ACCUM, VEND, CHANGE.
- Every nonzero D_in cycle counts as one coin. Upstream supplies single-cycle codes.
- IDLE/ACCUM, coin present, Cancel low: sum = Credit+VAL.
  - sum < PRICE: Credit<=sum, go to ACCUM.
  - sum >= PRICE: Credit<=sum-PRICE, go to VEND.
- VEND lasts exactly 1 cycle. Busy=1. Next state is CHANGE if Credit>0, else IDLE.
- CHANGE: Chg_pulse=1 every cycle, Credit decrements by 1 per edge. When Credit==1, next state is IDLE with Credit 0. N units of change give N back-to-back pulses.
- D_out timing:
  - MEALY=0: D_out=1 while in VEND, i.e. the cycle after the qualifying coin.
  - MEALY=1: D_out=1 combinationally in the cycle the qualifying coin is on D_in (state IDLE/ACCUM, sum>=PRICE). D_out=0 in VEND.
  - Chg_pulse is registered/Moore in both modes.
- Cancel in ACCUM with Credit>0: go to CHANGE and refund the full Credit, no D_out. Cancel in IDLE: no effect.
- Cancel and coin in the same cycle: Cancel wins and the coin is discarded (not credited).
- Coins and Cancel in VEND/CHANGE: ignored, not credited, not queued.
- Credit remains 0 in IDLE. D_out and Chg_pulse are never high in the same cycle.

Decomposition:
- Shared package vend_pkg: state typedef (IDLE, ACCUM, VEND, CHANGE) and the coin-code constants COIN_NONE/01/10/11.
- Sub-module vend_coin_dec: maps D_in to a unit value via VAL1..VAL3, output is 0 for code 00. Purely combinational, instantiated once.
- FSM, credit register and output logic stay in vend_ctrl_param.

Test Plan:
All scenarios use PRICE=5, VAL1=1, VAL2=2, VAL3=5.
1. Reset low 2 cycles mid-ACCUM with Credit=3 -> Credit=0, all outputs 0, state IDLE on the next cycle.
2. MEALY=0, coins 10,10,01 on consecutive cycles -> Credit 2,4 then D_out=1 for 1 cycle after the third coin. No Chg_pulse; Credit=0; Busy high 1 cycle.
3. MEALY=0, coins 10,10,11 -> Credit 9-5=4 in VEND. D_out 1 cycle, then exactly 4 consecutive Chg_pulse cycles with Credit 4,3,2,1. Then IDLE, Credit=0.
4. Coins 10,01 then Cancel -> 3 Chg_pulses, D_out never asserted. Cancel asserted again in IDLE -> no pulses.
5. Coin 11 presented during CHANGE -> ignored, pulse count unchanged. Cancel plus coin 10 in ACCUM with Credit=1 -> 1 Chg_pulse, coin not credited.
6. MEALY=1, coins 10,10,01 -> D_out high in the same cycle as code 01 and low in VEND. Separately, Reset low during the 2nd of 4 change pulses -> pulses stop immediately and Credit=0.
